// File: rtl/btn_pkg.sv
// Shared types and constants for the pushbutton debouncer.
// Defaults describe a 100 MHz board clock.
package btn_pkg;

  typedef enum logic [1:0] {
    LOW,
    WAIT_HIGH,
    HIGH,
    WAIT_LOW
  } deb_state_e;

  localparam int DEF_NUM_IN          = 5;
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_REPEAT_DELAY    = 50_000_000;
  localparam int DEF_REPEAT_RATE     = 10_000_000;

  // Counters never exceed n-1, so $clog2(n) bits suffice; keep at least one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: synchronizer, four-state debounce FSM, press/release pulses.
// Auto-repeat pulses are built only when BTN_AUTOREPEAT_EN is defined.
module debounce_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  deb_state_e             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= LOW;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Any return to the accepted level while waiting drops the candidate and clears the count.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      LOW: begin
        if (s) begin
          state_d = WAIT_HIGH;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_HIGH: begin
        if (!s) begin
          state_d = LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HIGH;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HIGH: begin
        if (!s) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_LOW: begin
        if (s) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = LOW;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = LOW;
        cnt_d   = '0;
      end
    endcase
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

`ifdef BTN_AUTOREPEAT_EN
  localparam int RW = cnt_width((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE);
  localparam logic [RW-1:0] REP_FIRST_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] REP_RATE_LAST  = RW'(REPEAT_RATE - 1);
  localparam logic [RW-1:0] REP_ONE        = RW'(1);

  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic          rep_first_q, rep_first_d;
  logic          repeat_q, repeat_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
      repeat_q    <= 1'b0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
      repeat_q    <= repeat_d;
    end
  end

  // Timing restarts whenever the channel is not sitting stably in HIGH.
  always_comb begin
    rep_cnt_d   = '0;
    rep_first_d = 1'b1;
    repeat_d    = 1'b0;
    if (state_q == HIGH && s) begin
      rep_first_d = rep_first_q;
      if (rep_cnt_q == (rep_first_q ? REP_FIRST_LAST : REP_RATE_LAST)) begin
        repeat_d    = 1'b1;
        rep_cnt_d   = '0;
        rep_first_d = 1'b0;
      end else begin
        rep_cnt_d = rep_cnt_q + REP_ONE;
      end
    end
  end

  assign repeat_o = repeat_q;
`else
  localparam int unused_repeat_cfg = REPEAT_DELAY + REPEAT_RATE;
  assign repeat_o = 1'b0;
`endif

endmodule

// File: rtl/button_debouncer.sv
// Debounces NUM_IN raw board buttons into clean levels and single-cycle pulses.
// Define BTN_AUTOREPEAT_EN to enable auto-repeat pulses on btn_repeat.
module button_debouncer
  import btn_pkg::*;
#(
  parameter int NUM_IN          = DEF_NUM_IN,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
  input  logic              CLK100MHZ,
  input  logic              rst,
  input  logic [NUM_IN-1:0] btn_raw,
  output logic [NUM_IN-1:0] btn_level,
  output logic [NUM_IN-1:0] btn_press,
  output logic [NUM_IN-1:0] btn_release,
  output logic [NUM_IN-1:0] btn_repeat
);

  for (genvar i = 0; i < NUM_IN; i++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE)
    ) u_chan (
      .clk_i    (CLK100MHZ),
      .rst_i    (rst),
      .raw_i    (btn_raw[i]),
      .level_o  (btn_level[i]),
      .press_o  (btn_press[i]),
      .release_o(btn_release[i]),
      .repeat_o (btn_repeat[i])
    );
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer with short debounce/repeat timings.
// Auto-repeat expectations follow BTN_AUTOREPEAT_EN.
module tb_button_debouncer;

  localparam int NUM_IN = 5;
  localparam int DEB    = 8;
  localparam int SYNC   = 2;
  localparam int RDELAY = 20;
  localparam int RRATE  = 5;
  localparam int LAT    = SYNC + DEB;

  logic              CLK100MHZ = 1'b0;
  logic              rst;
  logic [NUM_IN-1:0] btn_raw;
  logic [NUM_IN-1:0] btn_level, btn_press, btn_release, btn_repeat;

  int testsRun    = 0;
  int testsFailed = 0;

  always #5 CLK100MHZ = ~CLK100MHZ;

  button_debouncer #(
    .NUM_IN(NUM_IN), .DEBOUNCE_CYCLES(DEB), .SYNC_STAGES(SYNC),
    .REPEAT_DELAY(RDELAY), .REPEAT_RATE(RRATE)
  ) dut (
    .CLK100MHZ  (CLK100MHZ),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_repeat (btn_repeat)
  );

  // Reference: the synchronized input is the raw value SYNC edges old; a new level is
  // accepted once it has differed from the current level for DEB consecutive edges.
  logic [NUM_IN-1:0] mHist [SYNC];
  logic [NUM_IN-1:0] mS, mLevel, mPress, mRelease, mRepeat;
  int                mRun   [NUM_IN];
  int                mSince [NUM_IN];
  bit                mStay;

  always @(posedge CLK100MHZ) begin
    if (rst) begin
      for (int k = 0; k < SYNC; k++) mHist[k] = '0;
      mLevel = '0; mPress = '0; mRelease = '0; mRepeat = '0;
      for (int c = 0; c < NUM_IN; c++) begin
        mRun[c]   = 0;
        mSince[c] = 0;
      end
    end else begin
      mS = mHist[SYNC-1];
      for (int k = SYNC - 1; k > 0; k--) mHist[k] = mHist[k-1];
      mHist[0] = btn_raw;
      mPress = '0; mRelease = '0; mRepeat = '0;
      for (int c = 0; c < NUM_IN; c++) begin
        mStay = mLevel[c] && (mRun[c] == 0) && mS[c];
        if (mS[c] != mLevel[c]) begin
          mRun[c]++;
          if (mRun[c] == DEB) begin
            mRun[c]   = 0;
            mLevel[c] = ~mLevel[c];
            if (mLevel[c]) mPress[c] = 1'b1;
            else           mRelease[c] = 1'b1;
          end
        end else begin
          mRun[c] = 0;
        end
        mSince[c] = mStay ? mSince[c] + 1 : 0;
`ifdef BTN_AUTOREPEAT_EN
        if (mStay && mSince[c] >= RDELAY && ((mSince[c] - RDELAY) % RRATE) == 0)
          mRepeat[c] = 1'b1;
`endif
      end
    end
  end

  logic [NUM_IN-1:0] prevPress, prevRelease;
  logic [NUM_IN-1:0] pressAcc, releaseAcc, repeatAcc;
  int                pressCount   [NUM_IN];
  int                releaseCount [NUM_IN];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NUM_IN-1:0] raw, input bit rstVal);
    btn_raw = raw;
    rst     = rstVal;
  endtask

  task automatic clearAcc();
    pressAcc = '0; releaseAcc = '0; repeatAcc = '0;
    for (int c = 0; c < NUM_IN; c++) begin
      pressCount[c]   = 0;
      releaseCount[c] = 0;
    end
  endtask

  task automatic stepCycle();
    @(posedge CLK100MHZ);
    @(negedge CLK100MHZ);
    checkOutput("sb-level", 32'(btn_level), 32'(mLevel));
    checkOutput("sb-press", 32'(btn_press), 32'(mPress));
    checkOutput("sb-release", 32'(btn_release), 32'(mRelease));
    checkOutput("sb-repeat", 32'(btn_repeat), 32'(mRepeat));
    checkOutput("press-not-consecutive", 32'(btn_press & prevPress), 32'd0);
    checkOutput("release-not-consecutive", 32'(btn_release & prevRelease), 32'd0);
    prevPress   = btn_press;
    prevRelease = btn_release;
    pressAcc   |= btn_press;
    releaseAcc |= btn_release;
    repeatAcc  |= btn_repeat;
    for (int c = 0; c < NUM_IN; c++) begin
      pressCount[c]   += int'(btn_press[c]);
      releaseCount[c] += int'(btn_release[c]);
    end
  endtask

  task automatic waitFor(input bit isRelease, input logic [NUM_IN-1:0] mask,
                         input int maxCycles, output int lat);
    logic [NUM_IN-1:0] sig;
    lat = -1;
    for (int k = 1; k <= maxCycles; k++) begin
      stepCycle();
      sig = isRelease ? btn_release : btn_press;
      if ((sig & mask) == mask) begin
        lat = k;
        break;
      end
    end
  endtask

  typedef struct {
    logic [NUM_IN-1:0] raw;
    int                hold;
    logic [NUM_IN-1:0] expLevel;
    logic [NUM_IN-1:0] expPress;
    logic [NUM_IN-1:0] expRelease;
  } vec_t;

  vec_t              vecs [7];
  int                lat;
  int                repOffsets [$];
  int                expRep [$];
  logic [NUM_IN-1:0] rndRaw;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{5'b00010,  7, 5'b00000, 5'b00000, 5'b00000};
    vecs[1] = '{5'b00000, 12, 5'b00000, 5'b00000, 5'b00000};
    vecs[2] = '{5'b00010,  8, 5'b00000, 5'b00000, 5'b00000};
    vecs[3] = '{5'b00000, 12, 5'b00000, 5'b00010, 5'b00010};
    vecs[4] = '{5'b10101, 12, 5'b10101, 5'b10101, 5'b00000};
    vecs[5] = '{5'b01010, 12, 5'b01010, 5'b01010, 5'b10101};
    vecs[6] = '{5'b00000, 12, 5'b00000, 5'b00000, 5'b01010};

    prevPress = '0; prevRelease = '0;
    clearAcc();

    // Held buttons during reset stay silent, then press exactly LAT cycles after release.
    applyStimulus(5'b11111, 1'b1);
    for (int k = 0; k < 10; k++) begin
      stepCycle();
      checkOutput("reset-outputs-zero", 32'({btn_level, btn_press, btn_release, btn_repeat}), 32'd0);
    end
    applyStimulus(5'b11111, 1'b0);
    waitFor(1'b0, 5'b11111, 20, lat);
    checkOutput("reset-release-press-latency", 32'(lat), 32'(LAT));
    checkOutput("reset-release-level", 32'(btn_level), 32'h1F);
    applyStimulus(5'b00000, 1'b0);
    waitFor(1'b1, 5'b11111, 20, lat);
    checkOutput("release-all-latency", 32'(lat), 32'(LAT));

    // Clean single press on channel 0.
    applyStimulus(5'b00001, 1'b0);
    waitFor(1'b0, 5'b00001, 20, lat);
    checkOutput("ch0-press-latency", 32'(lat), 32'(LAT));
    checkOutput("ch0-level-with-press", 32'(btn_level[0]), 32'd1);
    stepCycle();
    checkOutput("ch0-press-single-cycle", 32'(btn_press[0]), 32'd0);
    applyStimulus(5'b00000, 1'b0);
    waitFor(1'b1, 5'b00001, 20, lat);
    checkOutput("ch0-release-latency", 32'(lat), 32'(LAT));

    for (int i = 0; i < 7; i++) begin
      clearAcc();
      applyStimulus(vecs[i].raw, 1'b0);
      for (int k = 0; k < vecs[i].hold; k++) stepCycle();
      checkOutput($sformatf("vec%0d-level", i), 32'(btn_level), 32'(vecs[i].expLevel));
      checkOutput($sformatf("vec%0d-press", i), 32'(pressAcc), 32'(vecs[i].expPress));
      checkOutput($sformatf("vec%0d-release", i), 32'(releaseAcc), 32'(vecs[i].expRelease));
    end

    // Channel 2 bounces every 3 cycles and finally settles high.
    clearAcc();
    for (int i = 0; i <= 10; i++) begin
      applyStimulus((i % 2 == 0) ? 5'b00100 : 5'b00000, 1'b0);
      if (i < 10) for (int k = 0; k < 3; k++) stepCycle();
    end
    waitFor(1'b0, 5'b00100, 20, lat);
    checkOutput("bounce-press-latency", 32'(lat), 32'(LAT));
    for (int k = 0; k < 5; k++) stepCycle();
    checkOutput("bounce-press-count", 32'(pressCount[2]), 32'd1);
    applyStimulus(5'b00000, 1'b0);
    waitFor(1'b1, 5'b00100, 20, lat);
    checkOutput("bounce-release-latency", 32'(lat), 32'(LAT));
    for (int k = 0; k < 5; k++) stepCycle();
    checkOutput("bounce-release-count", 32'(releaseCount[2]), 32'd1);

    // Press on ch3 and release on ch4 launched together report together.
    applyStimulus(5'b10000, 1'b0);
    for (int k = 0; k < 12; k++) stepCycle();
    checkOutput("ch4-held-level", 32'(btn_level), 32'h10);
    applyStimulus(5'b01000, 1'b0);
    waitFor(1'b0, 5'b01000, 20, lat);
    checkOutput("simul-press3-latency", 32'(lat), 32'(LAT));
    checkOutput("simul-release4-same-cycle", 32'(btn_release[4]), 32'd1);

    // Reset arriving mid-wait discards the pending press.
    clearAcc();
    applyStimulus(5'b01010, 1'b0);
    for (int k = 0; k < 5; k++) stepCycle();
    applyStimulus(5'b01010, 1'b1);
    stepCycle();
    applyStimulus(5'b00000, 1'b0);
    for (int k = 0; k < 15; k++) stepCycle();
    checkOutput("reset-midwait-press", 32'(pressAcc), 32'd0);
    checkOutput("reset-midwait-level", 32'(btn_level), 32'd0);

    // Long hold on ch0: repeats at fixed offsets from the press when enabled.
    clearAcc();
    applyStimulus(5'b00001, 1'b0);
    waitFor(1'b0, 5'b00001, 20, lat);
    checkOutput("hold-press-latency", 32'(lat), 32'(LAT));
    repeatAcc = '0;
    for (int k = 1; k <= 60; k++) begin
      if (k == 38) applyStimulus(5'b00000, 1'b0);
      stepCycle();
      if (btn_repeat[0]) repOffsets.push_back(k);
    end
`ifdef BTN_AUTOREPEAT_EN
    expRep.push_back(20); expRep.push_back(25); expRep.push_back(30); expRep.push_back(35);
`endif
    checkOutput("repeat-count", 32'(repOffsets.size()), 32'(expRep.size()));
    for (int i = 0; i < expRep.size() && i < repOffsets.size(); i++)
      checkOutput($sformatf("repeat-offset%0d", i), 32'(repOffsets[i]), 32'(expRep[i]));
    checkOutput("repeat-other-channels", 32'(repeatAcc & 5'b11110), 32'd0);

    // Random pin activity with occasional resets against the reference.
    rndRaw = '0;
    for (int n = 0; n < 900; n++) begin
      for (int c = 0; c < NUM_IN; c++)
        if ($urandom_range(0, 9) == 0) rndRaw[c] = ~rndRaw[c];
      applyStimulus(rndRaw, ($urandom_range(0, 199) == 0));
      stepCycle();
    end
    applyStimulus(rndRaw, 1'b0);
    for (int k = 0; k < 15; k++) stepCycle();
    checkOutput("random-final-level", 32'(btn_level), 32'(rndRaw));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
